// File: rtl/cache_req_initiator.sv
// CPU-side request initiator for the cache controller.
// Accepts one CPU request at a time, issues it to the cache as a single-cycle
// re/we strobe, then waits for cache_done (or a timeout) and returns a
// one-cycle response carrying read data or an error flag.
module cache_req_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  cache_re,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_done,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             we_q;      // captured request direction
    logic [CNT_W-1:0] wait_cnt;  // cycles spent in WAIT
    logic             accept;    // handshake completes this cycle
    logic             timeout;   // last permitted WAIT cycle

    assign timeout = (wait_cnt == CNT_LAST);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs (strobes, handshake, busy).
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_next = state;
        accept     = 1'b0;
        cpu_ready  = 1'b0;
        cache_re   = 1'b0;
        cache_we   = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                // Held low while reset is asserted so no request is taken.
                cpu_ready = rst;
                accept    = cpu_valid && rst;
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cache_re   = ~we_q;
                cache_we   = we_q;
                state_next = WAIT;
            end
            WAIT: begin
                if (cache_done || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, WAIT counter and response data/error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q        <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            wait_cnt    <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            // Address and write data stay frozen from ISSUE until the next accept.
            if (accept) begin
                we_q        <= cpu_we;
                cache_addr  <= cpu_addr;
                cache_wdata <= cpu_wdata;
            end

            // Counter saturates at TIMEOUT-1 because WAIT leaves on that value.
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !cache_done && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // Done takes priority over a coincident timeout.
            if (state == WAIT) begin
                if (cache_done) begin
                    resp_rdata <= we_q ? '0 : cache_rdata;
                    resp_err   <= 1'b0;
                end else if (timeout) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_req_initiator.sv
// Scoreboard bench for cache_req_initiator: stimulus pushes expected strobes
// and responses into queues, a negedge monitor pops and compares them.
module tb_cache_req_initiator;

    localparam int TIMEOUT = 15;

    logic       clk         = 1'b0;
    logic       rst         = 1'b0;
    logic       cpu_valid   = 1'b0;
    logic       cpu_we      = 1'b0;
    logic [7:0] cpu_addr    = 8'h00;
    logic [7:0] cpu_wdata   = 8'h00;
    logic [7:0] cache_rdata = 8'h00;
    logic       cache_done  = 1'b0;
    logic       cpu_ready;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic       cache_re;
    logic       cache_we;
    logic [7:0] cache_addr;
    logic [7:0] cache_wdata;
    logic       busy;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic       re;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } strobe_t;

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       err;
    } resp_t;

    strobe_t sq[$];
    resp_t   rq[$];

    cache_req_initiator #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .cache_re   (cache_re),
        .cache_we   (cache_we),
        .cache_addr (cache_addr),
        .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata),
        .cache_done (cache_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle c spans posedge c to posedge c+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe and response the DUT presents must match the queue head.
    always @(negedge clk) begin
        strobe_t s;
        resp_t   r;
        if (cache_re || cache_we) begin
            if (sq.size() == 0) begin
                check("unexpected_strobe", {30'd0, cache_re, cache_we}, 32'd0);
            end else begin
                s = sq.pop_front();
                check("strobe_cycle", cyc, s.cyc);
                check("strobe_re", cache_re, s.re);
                check("strobe_we", cache_we, s.we);
                check("strobe_addr", cache_addr, s.addr);
                check("strobe_wdata", cache_wdata, s.wdata);
            end
        end
        if (resp_valid) begin
            if (rq.size() == 0) begin
                check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
                r = rq.pop_front();
                check("resp_cycle", cyc, r.cyc);
                check("resp_rdata", resp_rdata, r.rdata);
                check("resp_err", resp_err, r.err);
            end
        end
    end

    // One request from the accept cycle until IDLE is re-entered.
    // d = cycles from strobe to cache_done; d<1 means never, d>TIMEOUT lands after timeout.
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input int d, input logic [7:0] rdata,
                          input bit keep_valid, input bit stray, output int t_acc);
        int n;
        bit to;
        to = (d < 1) || (d > TIMEOUT);
        n  = to ? TIMEOUT + 1 : d + 1;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (stray) begin
            cache_done  = 1'b1;
            cache_rdata = 8'h77;
        end
        #1;
        check("accept_ready", cpu_ready, 1);
        t_acc = cyc;
        sq.push_back('{t_acc + 1, !we, we, addr, wdata});
        rq.push_back('{t_acc + 1 + n, (to || we) ? 8'h00 : rdata, to});
        tick();
        cache_done  = 1'b0;
        cache_rdata = 8'hEE;
        if (!keep_valid) cpu_valid = 1'b0;
        check("issue_busy", busy, 1);
        check("issue_ready", cpu_ready, 0);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k < n) begin
                check("wait_busy", busy, 1);
                check("wait_ready", cpu_ready, 0);
                check("wait_addr", cache_addr, addr);
                check("wait_wdata", cache_wdata, wdata);
            end
            cache_done  = (k == d) || (stray && k == n);
            cache_rdata = (k == d) ? rdata : 8'hEE;
        end
        tick();
        cache_done = 1'b0;
        check("post_resp_ready", cpu_ready, 1);
        check("post_resp_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        int t0, t1, t2, t3;

        // Reset held low for two cycles.
        rst = 1'b0;
        tick();
        tick();
        check("rst_ready", cpu_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_strobes", {cache_re, cache_we}, 0);
        check("rst_addr", cache_addr, 0);
        check("rst_wdata", cache_wdata, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", cpu_ready, 1);
        tick();

        // Read hit: strobe T+1, done T+3, response T+4.
        do_req(1'b0, 8'h12, 8'h00, 2, 8'hA5, 1'b0, 1'b0, t0);
        // Write miss: done at strobe+3, response T+5, rdata forced to 0.
        do_req(1'b1, 8'h40, 8'h3C, 3, 8'h99, 1'b0, 1'b0, t0);
        // Timeout: no done, response T+17 with err.
        do_req(1'b0, 8'h55, 8'h00, -1, 8'h00, 1'b0, 1'b0, t0);
        // Done on last WAIT cycle (counter == TIMEOUT-1): done wins.
        do_req(1'b0, 8'h7F, 8'h00, TIMEOUT, 8'h5C, 1'b0, 1'b0, t0);
        // Done one cycle too late lands in RESP: timeout error, done ignored.
        do_req(1'b0, 8'h80, 8'h00, TIMEOUT + 1, 8'h99, 1'b0, 1'b0, t0);

        // Back-to-back hits with cpu_valid held high and stray done pulses.
        do_req(1'b0, 8'h01, 8'h11, 2, 8'hB1, 1'b1, 1'b1, t1);
        do_req(1'b1, 8'h02, 8'h22, 2, 8'hB2, 1'b1, 1'b1, t2);
        do_req(1'b0, 8'h03, 8'h33, 2, 8'hB3, 1'b1, 1'b1, t3);
        cpu_valid = 1'b0;
        check("b2b_spacing_1", t2 - t1, 5);
        check("b2b_spacing_2", t3 - t2, 5);

        // Reset one cycle after the strobe: request dropped, no response.
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 8'h5A;
        cpu_wdata = 8'h00;
        #1;
        check("rstmid_accept_ready", cpu_ready, 1);
        t0 = cyc;
        sq.push_back('{t0 + 1, 1'b1, 1'b0, 8'h5A, 8'h00});
        tick();
        cpu_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rstmid_busy_wait", busy, 1);
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", cpu_ready, 1);
        check("rstmid_rdata", resp_rdata, 0);
        check("rstmid_addr", cache_addr, 0);
        cache_done  = 1'b1;
        cache_rdata = 8'hC3;
        tick();
        cache_done = 1'b0;
        check("late_done_busy", busy, 0);
        tick();
        check("late_done_busy2", busy, 0);
        do_req(1'b0, 8'h21, 8'h00, 2, 8'h4B, 1'b0, 1'b0, t0);

        tick();
        tick();
        check("sb_strobes_left", sq.size(), 0);
        check("sb_resp_left", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
